// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and result bundle of the PS/2 host transmitter.
// The requester drives the command byte and request; the transmitter
// answers with ready, the end-of-transfer pulse and the result flags.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, done, ack_ok, err_timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, done, ack_ok, err_timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send sequence, 11-bit frame
// shifted out on the device clock, device ack check and timeout reporting.
// Line outputs are open-drain enables (1 = pull the line low).
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 2000
) (
    input  logic              clk,
    input  logic              reset,
    ps2_host_tx_if.slave      bus,
    input  logic              ps2_clk_in,
    input  logic              ps2_data_in,
    output logic              ps2_clk_oe,
    output logic              ps2_data_oe
);

    localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TO_CYC  = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int T_MAX   = (TO_CYC > INH_CYC) ? TO_CYC : INH_CYC;
    localparam int TW      = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] INH_LAST = TW'(INH_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAITREL,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic [9:0]    shift_reg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] timer;

    logic          clk_s;
    logic          data_s;
    logic          fall;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    // Two-flop synchronisers for the asynchronous PS/2 lines plus edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: idle PS/2 lines float high, so the synchronisers reset to 1
            // to avoid a phantom falling edge right after reset.
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous
            // stage's old value, which is what makes this a two-stage chain.
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_s;
        end
    end

    // Transfer state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.tx_ready    <= 1'b1;
            bus.done        <= 1'b0;
            bus.ack_ok      <= 1'b0;
            bus.err_timeout <= 1'b0;
            ps2_clk_oe      <= 1'b0;
            ps2_data_oe     <= 1'b0;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            timer           <= '0;
        end else begin
            // NOTE: done is a one-cycle pulse; defaulting it low here means
            // only the branches that finish a transfer need to mention it.
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (bus.tx_valid) begin
                        // Frame body LSB first: D0..D7, odd parity, stop.
                        shift_reg       <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        bus.ack_ok      <= 1'b0;
                        bus.err_timeout <= 1'b0;
                        bus.tx_ready    <= 1'b0;
                        ps2_clk_oe      <= 1'b1;
                        timer           <= '0;
                        state           <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer == INH_LAST) begin
                        timer       <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                REQ: begin
                    // Start bit stays on the data line; hand the clock to the device.
                    ps2_clk_oe <= 1'b0;
                    bit_cnt    <= '0;
                    timer      <= '0;
                    state      <= SEND;
                end
                SEND: begin
                    if (fall) begin
                        timer   <= '0;
                        bit_cnt <= (bit_cnt == 4'd11) ? bit_cnt : bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10) begin
                            bus.ack_ok  <= ~data_s;
                            ps2_data_oe <= 1'b0;
                            state       <= WAITREL;
                        end else begin
                            ps2_data_oe <= ~shift_reg[bit_cnt];
                        end
                    end else if (timer == TO_LAST) begin
                        ps2_clk_oe      <= 1'b0;
                        ps2_data_oe     <= 1'b0;
                        bus.err_timeout <= 1'b1;
                        bus.ack_ok      <= 1'b0;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAITREL: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (clk_s && data_s) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else if (fall) begin
                        timer <= '0;
                    end else if (timer == TO_LAST) begin
                        bus.err_timeout <= 1'b1;
                        bus.ack_ok      <= 1'b0;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    bus.tx_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    ps2_clk_oe   <= 1'b0;
                    ps2_data_oe  <= 1'b0;
                    bus.tx_ready <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks the frame,
// a scoreboard holds expected line bits and transfer results.
module tb_ps2_host_tx;

    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_line;
    logic ps2_data_line;

    ps2_host_tx_if bus ();

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ    (1_000_000),
        .INHIBIT_US(100),
        .TIMEOUT_US(2000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit       bit_q[$];
    logic [1:0] res_q[$];   // {ack_ok, err_timeout}

    int done_cnt = 0;
    int inh_cnt = 0;
    int req_cnt = 0;
    int start_cnt = 0;

    // Line-activity counters, read only while the transmitter is idle.
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
        if (ps2_clk_oe && ps2_data_oe) req_cnt++;
        if (!ps2_clk_oe && ps2_data_oe) start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one request; expected frame bits and result go to the scoreboard.
    task automatic send(input logic [7:0] d, input bit exp_ack, input bit exp_to, input bit hold);
        check("ready_before_accept", bus.tx_ready, 1'b1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
        bit_q.push_back(~^d);
        bit_q.push_back(1'b1);
        res_q.push_back({exp_ack, exp_to});
        @(negedge clk);
        if (!hold) bus.tx_valid = 1'b0;
        check("ready_after_accept", bus.tx_ready, 1'b0);
    endtask

    // Device model: clocks n_fall falling edges, checks bits before each fall.
    task automatic bfm(input int n_fall, input bit ack, input int hold_low);
        int guard = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("rts_seen", guard < 1000, 1'b1);
        for (int i = 0; i < 11; i++) begin
            cycles(HALF);
            if (bit_q.size() == 0) begin
                check("bit_queue_empty", 1'b1, 1'b0);
            end else begin
                check($sformatf("frame_bit%0d", i), ps2_data_line, bit_q.pop_front());
            end
            if (i == 10) begin
                dev_data_low = ack;
                cycles(5);
            end
            dev_clk_low = 1'b1;
            if (i + 1 == n_fall || i == 10) begin
                cycles((i == 10) ? hold_low : HALF);
                dev_clk_low = 1'b0;
                cycles(10);
                dev_data_low = 1'b0;
                return;
            end
            cycles(HALF);
            dev_clk_low = 1'b0;
        end
    endtask

    // Wait for the done pulse, compare result flags, then check ready returns.
    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        logic [1:0] exp;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, bus.done, 1'b1);
        bus.tx_valid = 1'b0;
        exp = (res_q.size() != 0) ? res_q.pop_front() : 2'bxx;
        check({tag, "_ack_ok"}, bus.ack_ok, exp[1]);
        check({tag, "_err_timeout"}, bus.err_timeout, exp[0]);
        check({tag, "_ready_in_done"}, bus.tx_ready, 1'b0);
        check({tag, "_oe_released"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
        @(negedge clk);
        check({tag, "_ready_after_done"}, bus.tx_ready, 1'b1);
        check({tag, "_done_one_cycle"}, bus.done, 1'b0);
    endtask

    initial begin
        int inh0, req0, st0, dn0;
        int ready_hi;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_ready", bus.tx_ready, 1'b1);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_flags", {bus.done, bus.ack_ok, bus.err_timeout}, 3'b000);

        // 1: 0xED with ack
        inh0 = inh_cnt; req0 = req_cnt;
        send(8'hED, 1'b1, 1'b0, 1'b0);
        fork
            bfm(11, 1'b1, HALF);
            wait_done(5000, "t1");
        join
        check("t1_inhibit_cycles", inh_cnt - inh0, 100);
        check("t1_req_cycles", req_cnt - req0, 1);
        cycles(20);

        // 2: 0x01, no ack
        send(8'h01, 1'b0, 1'b0, 1'b0);
        fork
            bfm(11, 1'b0, HALF);
            wait_done(5000, "t2");
        join
        cycles(20);

        // 3: 0xFF, device silent
        st0 = start_cnt;
        send(8'hFF, 1'b0, 1'b1, 1'b0);
        wait_done(3000, "t3");
        check("t3_cycles_to_timeout", start_cnt - st0, 2000);
        bit_q.delete();
        cycles(20);

        // 4: tx_valid held with changing data during the transfer
        dn0 = done_cnt; ready_hi = 0;
        send(8'h55, 1'b1, 1'b0, 1'b1);
        fork
            bfm(11, 1'b1, HALF);
            wait_done(5000, "t4");
            begin
                cycles(200);
                bus.tx_data = 8'hAA;
            end
            begin
                while (!bus.done) begin
                    if (bus.tx_ready) ready_hi++;
                    @(negedge clk);
                end
            end
        join
        inh0 = inh_cnt;
        cycles(300);
        check("t4_ready_low_during_xfer", ready_hi, 0);
        check("t4_single_done", done_cnt - dn0, 1);
        check("t4_no_second_frame", inh_cnt - inh0, 0);

        // 5: reset after the 4th falling edge, then 0xF4
        send(8'h12, 1'b0, 1'b0, 1'b0);
        bfm(4, 1'b0, HALF);
        dn0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_oe_after_reset", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("t5_ready_after_reset", bus.tx_ready, 1'b1);
        check("t5_no_done_at_reset", bus.done, 1'b0);
        bit_q.delete();
        res_q.delete();
        cycles(300);
        check("t5_no_done_after_reset", done_cnt - dn0, 0);
        send(8'hF4, 1'b1, 1'b0, 1'b0);
        fork
            bfm(11, 1'b1, HALF);
            wait_done(5000, "t5b");
        join
        cycles(20);

        // 6: 0x00, ack, then device holds clock low past the timeout
        send(8'h00, 1'b0, 1'b1, 1'b0);
        fork
            bfm(11, 1'b1, 3000);
            wait_done(8000, "t6");
        join
        cycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
